// File: rtl/ring_router_mux.sv
// ring_router_mux: merges the upstream ring stream and the local injection
// stream into one registered outgoing ring channel. Packets (worms) are never
// interleaved: once a head flit is granted, that input owns the output until
// its last flit is taken. Contention between packet heads is resolved
// round-robin by default.
//
// Build option: define RING_ROUTER_MUX_RING_PRIO_EN to give the ring input
// strict priority over local injection (no round-robin state is kept then).
module ring_router_mux (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_ring_data_i,
    input  logic        in_ring_last_i,
    input  logic        in_ring_valid_i,
    output logic        in_ring_ready_o,
    input  logic [15:0] in_local_data_i,
    input  logic        in_local_last_i,
    input  logic        in_local_valid_i,
    output logic        in_local_ready_o,
    output logic [15:0] out_ring_data_o,
    output logic        out_ring_last_o,
    output logic        out_ring_valid_o,
    input  logic        out_ring_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        WORM_RING,
        WORM_LOCAL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
`ifndef RING_ROUTER_MUX_RING_PRIO_EN
    logic        rrLastLocal_q, rrLastLocal_d;
`endif

    logic acc;
    logic selRing, selLocal;
    logic ringFire, localFire;

    // Pick which input may feed the output register this cycle and derive readys
    always_comb begin
        acc      = !valid_q || out_ring_ready_i;
        selRing  = 1'b0;
        selLocal = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_ring_valid_i && in_local_valid_i) begin
`ifdef RING_ROUTER_MUX_RING_PRIO_EN
                    selRing = 1'b1;
`else
                    selRing  = rrLastLocal_q;
                    selLocal = !rrLastLocal_q;
`endif
                end else begin
                    selRing  = in_ring_valid_i;
                    selLocal = in_local_valid_i;
                end
            end
            WORM_RING:  selRing  = 1'b1;
            WORM_LOCAL: selLocal = 1'b1;
            default: begin
                selRing  = 1'b0;
                selLocal = 1'b0;
            end
        endcase
        in_ring_ready_o  = selRing && acc;
        in_local_ready_o = selLocal && acc;
        ringFire         = in_ring_ready_o && in_ring_valid_i;
        localFire        = in_local_ready_o && in_local_valid_i;
    end

    // Next-state: output register load, worm locking and arbitration history
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifndef RING_ROUTER_MUX_RING_PRIO_EN
        rrLastLocal_d = rrLastLocal_q;
`endif
        if (acc) begin
            valid_d = ringFire || localFire;
            if (ringFire) begin
                data_d = in_ring_data_i;
                last_d = in_ring_last_i;
            end else if (localFire) begin
                data_d = in_local_data_i;
                last_d = in_local_last_i;
            end
        end
        if (ringFire) begin
            state_d = in_ring_last_i ? IDLE : WORM_RING;
        end else if (localFire) begin
            state_d = in_local_last_i ? IDLE : WORM_LOCAL;
        end
`ifndef RING_ROUTER_MUX_RING_PRIO_EN
        if (state_q == IDLE) begin
            if (ringFire) begin
                rrLastLocal_d = 1'b0;
            end else if (localFire) begin
                rrLastLocal_d = 1'b1;
            end
        end
`endif
    end

    // State and output register; reset drops any flit held for the link
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 16'h0000;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
`ifndef RING_ROUTER_MUX_RING_PRIO_EN
            rrLastLocal_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
`ifndef RING_ROUTER_MUX_RING_PRIO_EN
            rrLastLocal_q <= rrLastLocal_d;
`endif
        end
    end

    assign out_ring_data_o  = data_q;
    assign out_ring_last_o  = last_q;
    assign out_ring_valid_o = valid_q;

endmodule

// File: tb/tb_ring_router_mux.sv
// Testbench for ring_router_mux: source queues drive both inputs, every
// expected output flit is queued when the stimulus is set up and compared in
// order as the output channel transfers flits.
module tb_ring_router_mux;

    logic        clk;
    logic        rst;
    logic [15:0] ringData, localData, outData;
    logic        ringLast, ringValid, ringReady;
    logic        localLast, localValid, localReady;
    logic        outLast, outValid, outReady;

    int assertCount = 0;
    int failCount   = 0;

    logic [16:0] ringTxQ[$];
    logic [16:0] localTxQ[$];
    logic [16:0] expQ[$];
    bit          readyPatQ[$];

    int          cycleCnt = 0;
    int          ringFireCnt = 0;
    int          localFireCnt = 0;
    int          outFireCnt = 0;
    int          firstRingFireCyc = -1;
    int          firstOutCyc = -1;
    int          lastOutCyc = -1;
    bit          ringWormOpen = 0;
    bit          localWormOpen = 0;
    bit          prevStall = 0;
    bit          prevReset = 1;
    logic [16:0] prevFlit = '0;

    ring_router_mux dut (
        .clk              (clk),
        .rst              (rst),
        .in_ring_data_i   (ringData),
        .in_ring_last_i   (ringLast),
        .in_ring_valid_i  (ringValid),
        .in_ring_ready_o  (ringReady),
        .in_local_data_i  (localData),
        .in_local_last_i  (localLast),
        .in_local_valid_i (localValid),
        .in_local_ready_o (localReady),
        .out_ring_data_o  (outData),
        .out_ring_last_o  (outLast),
        .out_ring_valid_o (outValid),
        .out_ring_ready_i (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive at negedge, check just before posedge, retire on posedge
    task automatic applyStimulus(input bit doReset);
        bit          rf, lf, of;
        logic [16:0] obs;
        logic [16:0] exp;
        @(negedge clk);
        rst = doReset;
        if (ringTxQ.size() > 0) begin
            ringValid = 1'b1;
            {ringLast, ringData} = ringTxQ[0];
        end else begin
            ringValid = 1'b0;
            ringLast  = 1'b0;
            ringData  = 16'h0000;
        end
        if (localTxQ.size() > 0) begin
            localValid = 1'b1;
            {localLast, localData} = localTxQ[0];
        end else begin
            localValid = 1'b0;
            localLast  = 1'b0;
            localData  = 16'h0000;
        end
        outReady = (readyPatQ.size() > 0) ? readyPatQ.pop_front() : 1'b1;
        #4;
        rf  = ringValid && ringReady;
        lf  = localValid && localReady;
        of  = outValid && outReady;
        obs = {outLast, outData};
        checkOutput("ready_exclusive", 32'(ringReady && localReady), 32'd0);
        if (ringWormOpen) checkOutput("local_locked_out", 32'(localReady), 32'd0);
        if (localWormOpen) checkOutput("ring_locked_out", 32'(ringReady), 32'd0);
        if (prevReset) begin
            checkOutput("post_reset_valid", 32'(outValid), 32'd0);
            if (!localValid) checkOutput("post_reset_ring_ready", 32'(ringReady), 32'(ringValid));
        end else if (prevStall) begin
            checkOutput("stall_hold_valid", 32'(outValid), 32'd1);
            checkOutput("stall_hold_flit", 32'(obs), 32'(prevFlit));
        end
        if (of) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_flit", 32'(obs), 32'hFFFF_FFFF);
            end else begin
                exp = expQ.pop_front();
                checkOutput("out_flit", 32'(obs), 32'(exp));
            end
            outFireCnt++;
            if (firstOutCyc < 0) firstOutCyc = cycleCnt;
            lastOutCyc = cycleCnt;
        end
        if (rf && firstRingFireCyc < 0) firstRingFireCyc = cycleCnt;
        prevStall = outValid && !outReady;
        prevFlit  = obs;
        prevReset = doReset;
        @(posedge clk);
        cycleCnt++;
        if (rf) begin
            void'(ringTxQ.pop_front());
            ringFireCnt++;
            ringWormOpen = !ringLast;
        end
        if (lf) begin
            void'(localTxQ.pop_front());
            localFireCnt++;
            localWormOpen = !localLast;
        end
        if (doReset) begin
            ringWormOpen  = 1'b0;
            localWormOpen = 1'b0;
        end
    endtask

    // Run until all sources and the scoreboard are empty, within a cycle budget
    task automatic runUntilDrained(input string tag, input int maxCyc);
        int n = 0;
        while ((ringTxQ.size() + localTxQ.size() + expQ.size()) > 0 && n < maxCyc) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(ringTxQ.size() + localTxQ.size() + expQ.size()), 32'd0);
    endtask

    initial begin
        int n;
        int baseLocal;
        rst        = 1'b1;
        ringValid  = 1'b0;
        ringLast   = 1'b0;
        ringData   = 16'h0000;
        localValid = 1'b0;
        localLast  = 1'b0;
        localData  = 16'h0000;
        outReady   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(outValid), 32'd0);
        checkOutput("reset_data", 32'(outData), 32'd0);
        checkOutput("reset_last", 32'(outLast), 32'd0);
        checkOutput("reset_ring_ready", 32'(ringReady), 32'd0);
        checkOutput("reset_local_ready", 32'(localReady), 32'd0);

        // 3-flit ring packet alone
        $display("[TB] single-source ring packet");
        ringTxQ.push_back(17'h0_0005);
        ringTxQ.push_back(17'h0_1234);
        ringTxQ.push_back(17'h1_BEEF);
        expQ.push_back(17'h0_0005);
        expQ.push_back(17'h0_1234);
        expQ.push_back(17'h1_BEEF);
        firstRingFireCyc = -1;
        firstOutCyc = -1;
        outFireCnt = 0;
        runUntilDrained("t1", 20);
        checkOutput("t1_latency", 32'(firstOutCyc - firstRingFireCyc), 32'd1);
        checkOutput("t1_back_to_back", 32'(lastOutCyc - firstOutCyc), 32'd2);
        checkOutput("t1_out_count", 32'(outFireCnt), 32'd3);

        // Both inputs offer 2-flit packets right after reset: ring first
        $display("[TB] contention after reset");
        applyStimulus(1'b1);
        ringTxQ.push_back(17'h0_0101);
        ringTxQ.push_back(17'h1_0102);
        localTxQ.push_back(17'h0_0201);
        localTxQ.push_back(17'h1_0202);
        expQ.push_back(17'h0_0101);
        expQ.push_back(17'h1_0102);
        expQ.push_back(17'h0_0201);
        expQ.push_back(17'h1_0202);
        runUntilDrained("t2", 20);

        // Continuous single-flit packets from both inputs
        $display("[TB] continuous single-flit contention");
        for (int i = 0; i < 8; i++) begin
            ringTxQ.push_back({1'b1, 16'hA000 + 16'(i)});
            localTxQ.push_back({1'b1, 16'hB000 + 16'(i)});
        end
`ifdef RING_ROUTER_MUX_RING_PRIO_EN
        for (int i = 0; i < 8; i++) expQ.push_back({1'b1, 16'hA000 + 16'(i)});
        for (int i = 0; i < 8; i++) expQ.push_back({1'b1, 16'hB000 + 16'(i)});
`else
        for (int i = 0; i < 8; i++) begin
            expQ.push_back({1'b1, 16'hA000 + 16'(i)});
            expQ.push_back({1'b1, 16'hB000 + 16'(i)});
        end
`endif
        runUntilDrained("t3", 40);

        // Local 4-flit worm under output backpressure, ring waiting behind it
        $display("[TB] local worm with backpressure");
        readyPatQ.push_back(1'b1);
        readyPatQ.push_back(1'b0);
        readyPatQ.push_back(1'b0);
        readyPatQ.push_back(1'b1);
        readyPatQ.push_back(1'b1);
        readyPatQ.push_back(1'b0);
        readyPatQ.push_back(1'b1);
        for (int i = 1; i <= 4; i++) begin
            localTxQ.push_back({(i == 4), 16'h0C00 + 16'(i)});
            expQ.push_back({(i == 4), 16'h0C00 + 16'(i)});
        end
        applyStimulus(1'b0);
        ringTxQ.push_back(17'h1_1D00);
        expQ.push_back(17'h1_1D00);
        runUntilDrained("t4", 30);

        // Reset in the middle of a local worm; held flit must be discarded
        $display("[TB] reset mid-packet");
        baseLocal = localFireCnt;
        for (int i = 1; i <= 4; i++) localTxQ.push_back({(i == 4), 16'h0E00 + 16'(i)});
        expQ.push_back(17'h0_0E01);
        n = 0;
        while (localFireCnt < baseLocal + 2 && n < 10) begin
            applyStimulus(1'b0);
            n++;
        end
        checkOutput("t5_two_flits_taken", 32'(localFireCnt - baseLocal), 32'd2);
        readyPatQ.push_back(1'b0);
        applyStimulus(1'b1);
        localTxQ.delete();
        ringTxQ.push_back(17'h0_0F01);
        ringTxQ.push_back(17'h1_0F02);
        expQ.push_back(17'h0_0F01);
        expQ.push_back(17'h1_0F02);
        runUntilDrained("t5", 20);

        // Trailing idle cycles: nothing further may appear on the output
        repeat (3) applyStimulus(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
